unsigned_restoring_div_16by8: RTL and testbench

- Sequential unsigned radix-2 restoring divider; the inverse operation of the team's unsigned 8x8 (approximate) multipliers.
- Divides a 2W-bit product-domain dividend by a W-bit divisor, giving a W-bit quotient and a W-bit remainder.
- Sits downstream of the multiplier array. Used for round-trip error characterisation (z / y versus x) and as a reusable divide unit.
- Valid/ready on both input and output sides.

---
 rtl/unsigned_restoring_div_16by8.sv | 105 ++++++++++
 tb/tb_unsigned_restoring_div_16by8.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_restoring_div_16by8.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// One quotient bit per cycle; an early overflow check covers quotient overflow and divide by zero.
module unsigned_restoring_div_16by8 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic [W:0]     r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [W:0]     trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    // Q doubles as the dividend low half: its MSB shifts into R as quotient bits enter the LSB.
    trial     = {r_q[W-1:0], q_q[W-1]};
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dvs_d = divisor;
          if (dividend[2*W-1:W] >= divisor) begin
            q_d     = '1;
            r_d     = '0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = {1'b0, dividend[2*W-1:W]};
            q_d     = dividend[W-1:0];
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (trial >= {1'b0, dvs_q}) begin
          r_d = trial - {1'b0, dvs_q};
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = trial;
          q_d = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient  = q_q;
  assign remainder = r_q[W-1:0];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_unsigned_restoring_div_16by8.sv
// Randomised and directed bench for the 16/8 restoring divider against a plain-arithmetic model.
module tb_unsigned_restoring_div_16by8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  unsigned_restoring_div_16by8 #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Division by definition: overflow when the quotient cannot fit in 8 bits.
  function automatic void model(input logic [15:0] dvd, input logic [7:0] dvs,
                                output logic [7:0] q, output logic [7:0] r, output logic o);
    if (dvs == 8'd0 || (dvd >> 8) >= 16'(dvs)) begin
      q = 8'hFF; r = 8'd0; o = 1'b1;
    end else begin
      q = 8'(dvd / 16'(dvs)); r = 8'(dvd % 16'(dvs)); o = 1'b0;
    end
  endfunction

  logic [15:0] e_dvd = '0;
  logic [7:0]  e_dvs = '0;
  logic [7:0]  mq, mr, h_q, h_r;
  logic        mo, h_o;
  bit          hold_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (out_valid) begin
        model(e_dvd, e_dvs, mq, mr, mo);
        chk("quotient", 32'(quotient), 32'(mq));
        chk("remainder", 32'(remainder), 32'(mr));
        chk("ovf", 32'(ovf), 32'(mo));
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (!mo)
          chk("identity", 32'(quotient) * 32'(e_dvs) + 32'(remainder), 32'(e_dvd));
      end
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_q", 32'(quotient), 32'(h_q));
        chk("hold_r", 32'(remainder), 32'(h_r));
        chk("hold_ovf", 32'(ovf), 32'(h_o));
      end
      hold_prev = out_valid && !out_ready;
      h_q = quotient; h_r = remainder; h_o = ovf;
      if (in_valid && in_ready) begin
        e_dvd = dividend;
        e_dvs = divisor;
      end
    end
  end

  // One operation; junk operands stay valid while busy to show they are ignored.
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, input int stall,
                        output logic [7:0] q, output logic [7:0] r, output logic o, output int lat);
    int n;
    out_ready = (stall == 0);
    dividend  = dvd;
    divisor   = dvs;
    in_valid  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) chk("done_timeout", 32'(out_valid), 32'd1);
    q = quotient; r = remainder; o = ovf;
    if (stall == 0) in_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]  q, r, rq, rr, y;
    logic        o, ro;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    int          lat, n;
    bit          first;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd12345, 8'd97, 0, q, r, o, lat);
    chk("d1_lat", 32'(lat), 32'd9);
    chk("d1_q", 32'(q), 32'd127);
    chk("d1_r", 32'(r), 32'd26);
    chk("d1_ovf", 32'(o), 32'd0);

    run_op(16'd65025, 8'd255, 1, q, r, o, lat);
    chk("max_q", 32'(q), 32'd255);
    chk("max_r", 32'(r), 32'd0);
    chk("max_ovf", 32'(o), 32'd0);

    run_op(16'd0, 8'd7, 0, q, r, o, lat);
    chk("zero_q", 32'(q), 32'd0);
    chk("zero_r", 32'(r), 32'd0);

    run_op(16'h1234, 8'h10, 2, q, r, o, lat);
    chk("ovf1_lat", 32'(lat), 32'd1);
    chk("ovf1_q", 32'(q), 32'hFF);
    chk("ovf1_r", 32'(r), 32'd0);
    chk("ovf1_ovf", 32'(o), 32'd1);

    run_op(16'h0005, 8'd0, 0, q, r, o, lat);
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_q", 32'(q), 32'hFF);
    chk("div0_ovf", 32'(o), 32'd1);

    run_op(16'd200, 8'd1, 0, q, r, o, lat);
    chk("div1_q", 32'(q), 32'd200);

    // Backpressure: five stalled cycles in DONE with junk requests offered.
    run_op(16'd200, 8'd3, 5, q, r, o, lat);
    chk("bp_q", 32'(q), 32'd66);
    chk("bp_r", 32'(r), 32'd2);

    // Reset pulse mid-CALC, then a fresh operation.
    dividend = 16'd12345; divisor = 8'd97; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_calc_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_quotient", 32'(quotient), 32'd0);
    chk("arst_remainder", 32'(remainder), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'd200, 8'd3, 0, q, r, o, lat);
    chk("post_rst_lat", 32'(lat), 32'd9);
    chk("post_rst_q", 32'(q), 32'd66);
    chk("post_rst_r", 32'(r), 32'd2);
    chk("post_rst_ovf", 32'(o), 32'd0);

    // Random operands: half unconstrained (mostly overflow), half in-range.
    for (int i = 0; i < 300; i++) begin
      dvs = 8'($urandom);
      if (i % 2 == 1 || dvs == 8'd0) dvd = 16'($urandom);
      else dvd = 16'($urandom_range(0, 32'(dvs) * 256 - 1));
      run_op(dvd, dvs, int'($urandom_range(0, 3)), q, r, o, lat);
      model(dvd, dvs, rq, rr, ro);
      chk("rand_lat", 32'(lat), ro ? 32'd1 : 32'd9);
    end

    // Round-trip sweep, back to back with out_ready high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    first     = 1'b1;
    for (int x = 0; x < 256; x++) begin
      for (int k = 0; k < 3; k++) begin
        y = (k == 0) ? 8'd1 : (k == 1) ? 8'd255 : 8'($urandom_range(2, 254));
        dividend = 16'(x * int'(y));
        divisor  = y;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 50);
        chk("sweep_accept", 32'(in_ready), 32'd1);
        if (!first) chk("sweep_spacing", 32'(n), 32'd10);
        first = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("sweep_idle", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
